bit_packer: RTL

- Serial-to-parallel front end that sits directly upstream of the encoder.
- Collects a serial bit stream into BITS_WIDTH-bit words.
- Buffers completed words in a 2-entry output FIFO and presents them on a valid/ready interface to the encoder's data input.
- Handles frame alignment via a start-of-frame strobe and applies backpressure to the bit source.

---
 rtl/bit_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bit_packer.sv
// bit_packer: collects a serial bit stream into BITS_WIDTH-bit words and hands
// them to the encoder through a 2-entry valid/ready FIFO. A start-of-frame
// strobe realigns word boundaries; an abandoned partial word is reported with
// a one-cycle partial_drop pulse.
// Build option: define BITPACK_MSB_FIRST_EN for MSB-first packing (the first
// accepted bit of a word lands in the top bit). Default is LSB-first.
// All outputs come straight from flops; bit_ready is computed from next-state
// values so it has no combinational path from data_ready.
module bit_packer #(
  parameter int BITS_WIDTH = 5,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  bit_sof,
  output logic                  bit_ready,
  output logic [BITS_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  partial_drop
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BITS_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};
  localparam logic [BITS_WIDTH-1:0] ZERO_W  = {BITS_WIDTH{1'b0}};

  // Word assembly state
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BITS_WIDTH-1:0] shreg_q, shreg_d;

  // FIFO state
  logic [BITS_WIDTH-1:0] mem_q [2];
  logic [BITS_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  // Registered outputs
  logic [BITS_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  bit_ready_q, bit_ready_d;
  logic                  drop_q, drop_d;

  // Handshake and datapath helpers
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_WIDTH-1:0]  bit_idx_s;
  logic [CNT_WIDTH-1:0]  pos_s;
  logic [BITS_WIDTH-1:0] word_s;

  // Handshakes and the word formed by merging the incoming bit
  always_comb begin
    accept_s  = bit_valid && bit_ready_q;
    pop_s     = data_valid_q && data_ready;
    // A sof bit always starts a fresh word at index 0.
    bit_idx_s = bit_sof ? ZERO_CNT : cnt_q;
`ifdef BITPACK_MSB_FIRST_EN
    pos_s     = LAST_CNT - bit_idx_s;
`else
    pos_s     = bit_idx_s;
`endif
    word_s    = (bit_sof ? ZERO_W : shreg_q) | (BITS_WIDTH'(bit_in) << pos_s);
    // A sof bit can never complete a word since BITS_WIDTH >= 2.
    push_s    = accept_s && !bit_sof && (cnt_q == LAST_CNT);
  end

  // Bit counter, shift register and partial-drop detection
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    drop_d  = 1'b0;
    if (accept_s) begin
      if (bit_sof) begin
        drop_d  = (cnt_q != ZERO_CNT);
        cnt_d   = ONE_CNT;
        shreg_d = word_s;
      end else if (cnt_q == LAST_CNT) begin
        cnt_d   = ZERO_CNT;
        shreg_d = ZERO_W;
      end else begin
        cnt_d   = cnt_q + ONE_CNT;
        shreg_d = word_s;
      end
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  // FIFO pointers, storage and occupancy
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = word_s;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    data_valid_d = (occ_d != 2'd0);
    // data keeps its last value once the FIFO drains.
    if (occ_d != 2'd0) begin
      data_d = mem_d[rd_ptr_d];
    end else begin
      data_d = data_q;
    end
    // Only the word-completing bit is refused, and only when there is no room.
    bit_ready_d = !((occ_d == 2'd2) && (cnt_d == LAST_CNT));
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= ZERO_CNT;
      shreg_q      <= ZERO_W;
      mem_q[0]     <= ZERO_W;
      mem_q[1]     <= ZERO_W;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      data_q       <= ZERO_W;
      data_valid_q <= 1'b0;
      bit_ready_q  <= 1'b1;
      drop_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      bit_ready_q  <= bit_ready_d;
      drop_q       <= drop_d;
    end
  end

  assign bit_ready    = bit_ready_q;
  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign partial_drop = drop_q;

endmodule
